// File: rtl/or_8.sv
`default_nettype none
// ============================================================================
// Module   : or_8
// Purpose  : Registered 8-bit bitwise OR unit for the ALU datapath.
//            z <= a | b on each valid operation, or a | b | z when the
//            accumulate qualifier is set. Status flags are derived from
//            the registered result.
// Macro    : OR8_FLAGS_EN - when defined, zero/ones/parity are driven from
//            z; when undefined the flag logic is not built and the three
//            flag ports are tied to 0 (port list unchanged).
// Ports    : clk       - clock, rising edge
//            rst_n     - asynchronous active-low reset
//            a, b      - operands
//            in_valid  - operands valid, capture result this cycle
//            acc       - OR new result into the held value (with in_valid)
//            z         - registered result
//            out_valid - one-cycle pulse per captured operation
//            zero      - z == 0
//            ones      - z == all ones
//            parity    - XOR reduction of z
// Revision : 1.0 - initial release
// ============================================================================
module or_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             acc,
    output logic [WIDTH-1:0] z,
    output logic             out_valid,
    output logic             zero,
    output logic             ones,
    output logic             parity
);

    logic [WIDTH-1:0] r_z;
    logic             r_out_valid;
    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] w_next;

    // Accumulate folds the held value back in; gating with acc keeps the
    // plain path free of any dependency on the previous result.
    assign w_or   = a | b;
    assign w_next = acc ? (w_or | r_z) : w_or;

    // Capture is gated by in_valid inside the register enable, so unknown
    // operands on idle cycles never reach r_z.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_z <= w_next;
            end
        end
    end

    assign z         = r_z;
    assign out_valid = r_out_valid;

`ifdef OR8_FLAGS_EN
    assign zero   = (r_z == '0);
    assign ones   = &r_z;
    assign parity = ^r_z;
`else
    assign zero   = 1'b0;
    assign ones   = 1'b0;
    assign parity = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_or_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_or_8
// Purpose  : Self-checking bench for or_8. A driver pushes hand-computed
//            expected results into a queue as it issues operations; a
//            monitor pops and compares whenever out_valid is seen.
//            Flag expectations follow OR8_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_or_8;

`ifdef OR8_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] z;
        logic       zero;
        logic       ones;
        logic       parity;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid;
    logic       acc;
    logic [7:0] z;
    logic       out_valid;
    logic       zero;
    logic       ones;
    logic       parity;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    or_8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .acc       (acc),
        .z         (z),
        .out_valid (out_valid),
        .zero      (zero),
        .ones      (ones),
        .parity    (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        total_cnt++;
        if (act === expv) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    // Flags expected from a hand-computed result value.
    function automatic exp_t mk_exp(input logic [7:0] ez);
        exp_t e;
        e.z      = ez;
        e.zero   = FLAGS_EN && (ez == 8'h00);
        e.ones   = FLAGS_EN && (ez == 8'hFF);
        e.parity = FLAGS_EN && (^ez);
        return e;
    endfunction

    task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vacc,
                        input logic [7:0] ez);
        @(posedge clk);
        #1;
        a        = va;
        b        = vb;
        acc      = vacc;
        in_valid = 1'b1;
        exp_q.push_back(mk_exp(ez));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        a        = 8'bx;
        b        = 8'bx;
        acc      = 1'b1;
        in_valid = 1'b0;
    endtask

    // One cycle later, z must equal ez and out_valid must be low.
    task automatic check_hold(input string name, input logic [7:0] ez);
        @(posedge clk);
        @(negedge clk);
        check({name, "_z"}, z, ez);
        check({name, "_ov"}, {7'd0, out_valid}, 8'd0);
    endtask

    // Monitor: pops one expected entry per presented result.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_z", z, e.z);
                check("sb_zero", {7'd0, zero}, {7'd0, e.zero});
                check("sb_ones", {7'd0, ones}, {7'd0, e.ones});
                check("sb_parity", {7'd0, parity}, {7'd0, e.parity});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b1;
        a        = 8'h00;
        b        = 8'h00;
        acc      = 1'b0;
        in_valid = 1'b0;

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("rst_z", z, 8'h00);
        check("rst_ov", {7'd0, out_valid}, 8'd0);
        check("rst_zero", {7'd0, zero}, {7'd0, FLAGS_EN});
        check("rst_ones", {7'd0, ones}, 8'd0);
        check("rst_parity", {7'd0, parity}, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_hold("idle0", 8'h00);
        check_hold("idle1", 8'h00);

        // Directed back-to-back vectors.
        send(8'b00010010, 8'b01000101, 1'b0, 8'b01010111);
        send(8'b00010110, 8'b01010101, 1'b0, 8'b01010111);
        send(8'b10010010, 8'b01000111, 1'b0, 8'b11010111);
        send(8'b00010011, 8'b01000100, 1'b0, 8'b01010111);
        send(8'b00011010, 8'b00000101, 1'b0, 8'b00011111);
        send(8'b00110010, 8'b11000101, 1'b0, 8'b11110111);
        send(8'b00010110, 8'b01000001, 1'b0, 8'b01010111);

        // Flag vectors.
        send(8'b00000000, 8'b00000000, 1'b0, 8'b00000000);
        send(8'b11110000, 8'b00001111, 1'b0, 8'b11111111);
        send(8'b00000001, 8'b00000000, 1'b0, 8'b00000001);

        // Accumulate, then idle with unknown operands.
        send(8'b00000001, 8'b00000010, 1'b0, 8'b00000011);
        send(8'b00010000, 8'b00000000, 1'b1, 8'b00010011);
        idle();
        check_hold("acc_hold0", 8'b00010011);
        check_hold("acc_hold1", 8'b00010011);
        check_hold("acc_hold2", 8'b00010011);
        check("queue_drained", 8'(exp_q.size()), 8'd0);

        // Mid-stream reset: pending result discarded, out_valid drops at once.
        send(8'hA5, 8'h00, 1'b0, 8'hA5);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_z", z, 8'h00);
        check("mid_rst_ov", {7'd0, out_valid}, 8'd0);
        check("mid_rst_zero", {7'd0, zero}, {7'd0, FLAGS_EN});
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // First operation after reset with acc set behaves as a plain OR.
        send(8'h21, 8'h04, 1'b1, 8'h25);
        idle();
        check_hold("post_rst_hold", 8'h25);
        check("queue_final", 8'(exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
